microc_stk: RTL and testbench
=============================

# microc_stk

Parametrised single-cycle microcontroller datapath, the successor to the fixed 10-bit-PC core. Adds a hardware return-address stack for subroutine call/return, a parametrised PC width and stack depth, and stack status flags. The program memory is external (instruction fetch port). The external control unit decodes `Opcode` and drives the select/enable lines.

## Interface
- `PC_W`, 10: program counter and jump-target width, 2..10.
- `STK_DEPTH`, 4: return-stack entries, power of two, 2..16.
- `clk` input 1: single clock; all state updates on rising edge.
- `reset` input 1: asynchronous, active-low; clears all state immediately.
- `pc` output PC_W: current instruction address, to program memory.
- `instr` input 16: instruction word at `pc`, combinational from memory.
- `Opcode` output 6: `instr[15:10]`.
- `zero` output 1: registered zero flag.
- `s_inc` input 1: 1 = PC+1, 0 = jump to `instr[PC_W-1:0]`.
- `s_inm` input 1: 1 = immediate operand `instr[11:4]` and read port 1 addresses `instr[3:0]`; 0 = register operands `instr[11:8]` and `instr[7:4]`.
- `we` input 1: register-file write enable, write address `instr[3:0]`.
- `wez` input 1: zero-flag write enable.
- `ALUOp` input 3: ALU function.
- `s_call` input 1: push PC+1, then jump (requires `s_inc`=0).
- `s_ret` input 1: pop the top of stack into PC.
- `stk_empty` output 1: stack pointer = 0.
- `stk_full` output 1: stack pointer = STK_DEPTH.
- `stk_err` output 1: sticky overflow/underflow flag (guard build only; tied 0 otherwise).

## Operation
- Register file: 16 x 8 bits, two combinational read ports, one synchronous write port. Register 0 always reads 0, and writes to it are discarded.
- ALU (8-bit, result wraps mod 256), keyed by `ALUOp`:
  - 000: A
  - 001: ~A
  - 010: A+B
  - 011: A-B
  - 100: A&B
  - 101: A|B
  - 110: -A
  - 111: -B
- ALU result is the write data. `zero` <= (result == 0) when `wez`=1, else it holds.
- Next-PC priority:
  - `s_ret`=1: PC <= stack top, sp <= sp-1.
  - else `s_inc`=0: PC <= jump target. If `s_call`=1 also, stack[sp] <= PC+1 and sp <= sp+1.
  - else PC <= PC+1, wrapping mod 2^PC_W.
- `s_call` together with `s_inc`=1 is ignored: no push, normal increment.
- `s_call` and `s_ret` both 1: the return wins and there is no push.
- Stack pointer width is clog2(STK_DEPTH)+1. Entries are PC_W wide.
- Register write, flag write and PC/stack update all occur on the same edge.

## Timing
- Every instruction completes in one cycle. There are no stalls and no handshakes.
- `pc` is a register output. `Opcode` is combinational from `instr`.
- `stk_empty`, `stk_full` and `stk_err` are registered state, or decoded combinationally from sp only.
- Reset values (asserted asynchronously while `reset`=0):
  - pc = 0
  - zero = 0
  - sp = 0, so stk_empty = 1 and stk_full = 0
  - stk_err = 0
  - all registers = 0
  - stack entries = 0
- Reset in mid-call discards the stack. Execution restarts at address 0.
- Boundary cases without the guard:
  - Push when full: the entry at index sp mod STK_DEPTH is overwritten, and sp stays at STK_DEPTH, saturating.
  - Pop when empty: PC <= stack[0], and sp stays 0.

## Configuration
- Macro: `MICROC_STK_GUARD_EN`.
- When defined:
  - A push when full is suppressed and the jump still occurs.
  - A pop when empty is suppressed and PC <= PC+1.
  - Either event sets `stk_err` = 1. It stays 1 until reset.
- When undefined: the unguarded boundary behaviour in Timing applies, and `stk_err` is constant 0.

## Test plan
- Reset low mid-run -> pc=0, zero=0, stk_empty=1, and r1..r15 read 0 immediately, without a clock edge.
- `s_inm`=1, instr immediate 0x05 to r1, ALUOp=000, we=1, wez=1. Then r1-r1 with ALUOp=011, wez=1 -> r1=0x05, then zero=1. Also an add of 0xFF+0x01 -> result 0x00 and zero=1.
- At pc=3, call to 0x20 -> pc=0x20, stk_empty=0. Then ret -> pc=4, stk_empty=1.
- STK_DEPTH=4 nested calls to full, then a fifth call:
  - guard build -> jump taken, stk_err=1, four returns restore the addresses in LIFO order.
  - plain build -> stk_full stays 1.
- Ret from an empty stack:
  - guard build -> pc increments and stk_err=1.
  - plain build -> pc = stack[0].
- s_call=1 and s_ret=1 at the same time with one entry stacked -> pc = popped address, sp decrements, no push. Also PC_W=4 at pc=15 with increment -> pc=0.

Source files
------------

// File: rtl/microc_stk.sv
// -----------------------------------------------------------------------------
// microc_stk - single-cycle 8-bit microcontroller datapath with a hardware
// return-address stack.
//
// Parameters:
//   PC_W      program counter / jump-target width (2..10)
//   STK_DEPTH return-stack entries, power of two (2..16)
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   pc         current instruction address (registered)
//   instr      instruction word at pc (combinational from program memory)
//   Opcode     instr[15:10], for the external control unit
//   zero       registered zero flag
//   s_inc      1 = PC+1, 0 = jump to instr[PC_W-1:0]
//   s_inm      1 = A is immediate instr[11:4], B is reg[instr[3:0]]
//              0 = A is reg[instr[11:8]],      B is reg[instr[7:4]]
//   we         register write enable, write address instr[3:0]
//   wez        zero-flag write enable
//   ALUOp      ALU function select
//   s_call     push PC+1 and jump (only when s_inc = 0)
//   s_ret      pop top of stack into PC (has priority over everything)
//   stk_empty  stack pointer == 0
//   stk_full   stack pointer == STK_DEPTH
//   stk_err    sticky overflow/underflow flag
//
// Build option: define MICROC_STK_GUARD_EN to suppress pushes on a full stack
// and pops on an empty stack and record them in stk_err. Without it the stack
// overwrites/saturates and stk_err is tied to 0.
// -----------------------------------------------------------------------------
module microc_stk #(
    parameter int PC_W      = 10,
    parameter int STK_DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    output logic [PC_W-1:0] pc,
    input  logic [15:0]     instr,
    output logic [5:0]      Opcode,
    output logic            zero,
    input  logic            s_inc,
    input  logic            s_inm,
    input  logic            we,
    input  logic            wez,
    input  logic [2:0]      ALUOp,
    input  logic            s_call,
    input  logic            s_ret,
    output logic            stk_empty,
    output logic            stk_full,
    output logic            stk_err
);
    localparam int AW  = $clog2(STK_DEPTH);
    localparam int SPW = AW + 1;

    logic [7:0]      r_rf  [16];
    logic [PC_W-1:0] r_stk [STK_DEPTH];
    logic [PC_W-1:0] r_pc;
    logic [SPW-1:0]  r_sp;
    logic            r_zero;

    logic [3:0]      w_ra1;
    logic [7:0]      w_rd1;
    logic [7:0]      w_rd2;
    logic [7:0]      w_a;
    logic [7:0]      w_b;
    logic [7:0]      w_alu;
    logic [PC_W-1:0] w_pc_inc;
    logic [PC_W-1:0] w_pc_next;
    logic [SPW-1:0]  w_sp_next;
    logic            w_push;
    logic [AW-1:0]   w_pop_idx;
    logic            w_sp_empty;
    logic            w_sp_full;
`ifdef MICROC_STK_GUARD_EN
    logic            w_err_set;
    logic            r_err;
`endif

    assign Opcode = instr[15:10];
    assign pc     = r_pc;
    assign zero   = r_zero;

    // Operand selection: in immediate mode read port 1 moves to the
    // destination field so an immediate can be combined with rd itself.
    assign w_ra1 = s_inm ? instr[3:0] : instr[11:8];
    assign w_rd1 = (w_ra1 == 4'd0) ? 8'd0 : r_rf[w_ra1];
    assign w_rd2 = (instr[7:4] == 4'd0) ? 8'd0 : r_rf[instr[7:4]];
    assign w_a   = s_inm ? instr[11:4] : w_rd1;
    assign w_b   = s_inm ? w_rd1 : w_rd2;

    always_comb begin
        w_alu = w_a;
        unique case (ALUOp)
            3'b000: w_alu = w_a;
            3'b001: w_alu = ~w_a;
            3'b010: w_alu = w_a + w_b;
            3'b011: w_alu = w_a - w_b;
            3'b100: w_alu = w_a & w_b;
            3'b101: w_alu = w_a | w_b;
            3'b110: w_alu = 8'd0 - w_a;
            3'b111: w_alu = 8'd0 - w_b;
            default: w_alu = w_a;
        endcase
    end

    assign w_sp_empty = (r_sp == '0);
    assign w_sp_full  = (r_sp == SPW'(STK_DEPTH));
    assign stk_empty  = w_sp_empty;
    assign stk_full   = w_sp_full;

    assign w_pc_inc  = r_pc + PC_W'(1);
    // An empty pop reads entry 0 rather than wrapping to the last entry.
    assign w_pop_idx = w_sp_empty ? '0 : AW'(r_sp - SPW'(1));

    always_comb begin
        w_pc_next = w_pc_inc;
        w_sp_next = r_sp;
        w_push    = 1'b0;
`ifdef MICROC_STK_GUARD_EN
        w_err_set = 1'b0;
`endif
        if (s_ret) begin
            if (w_sp_empty) begin
`ifdef MICROC_STK_GUARD_EN
                w_pc_next = w_pc_inc;
                w_err_set = 1'b1;
`else
                w_pc_next = r_stk[w_pop_idx];
`endif
            end else begin
                w_pc_next = r_stk[w_pop_idx];
                w_sp_next = r_sp - SPW'(1);
            end
        end else if (!s_inc) begin
            w_pc_next = instr[PC_W-1:0];
            if (s_call) begin
                if (w_sp_full) begin
`ifdef MICROC_STK_GUARD_EN
                    w_err_set = 1'b1;
`else
                    // Saturate sp, overwrite entry sp mod depth.
                    w_push    = 1'b1;
`endif
                end else begin
                    w_push    = 1'b1;
                    w_sp_next = r_sp + SPW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc   <= '0;
            r_sp   <= '0;
            r_zero <= 1'b0;
            for (int i = 0; i < 16; i++) r_rf[i] <= 8'd0;
            for (int i = 0; i < STK_DEPTH; i++) r_stk[i] <= '0;
        end else begin
            r_pc <= w_pc_next;
            r_sp <= w_sp_next;
            if (wez) r_zero <= (w_alu == 8'd0);
            if (we && (instr[3:0] != 4'd0)) r_rf[instr[3:0]] <= w_alu;
            if (w_push) r_stk[r_sp[AW-1:0]] <= w_pc_inc;
        end
    end

`ifdef MICROC_STK_GUARD_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)         r_err <= 1'b0;
        else if (w_err_set) r_err <= 1'b1;
    end
    assign stk_err = r_err;
`else
    assign stk_err = 1'b0;
`endif

endmodule

// File: tb/tb_microc_stk.sv
module tb_microc_stk;
    localparam int  PCW   = 10;
    localparam int  DEPTH = 4;
`ifdef MICROC_STK_GUARD_EN
    localparam bit  GUARD = 1'b1;
`else
    localparam bit  GUARD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] instr = 16'h0;
    logic        s_inc = 1'b1, s_inm = 1'b0, we = 1'b0, wez = 1'b0;
    logic [2:0]  ALUOp = 3'd0;
    logic        s_call = 1'b0, s_ret = 1'b0;

    logic [PCW-1:0] pc;
    logic [5:0]     Opcode;
    logic           zero, stk_empty, stk_full, stk_err;
    logic [3:0]     pc4;
    logic [5:0]     opcode4;
    logic           zero4, empty4, full4, err4;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    logic [PCW-1:0] m_pc;
    logic [7:0]     m_regs [16];
    logic [PCW-1:0] m_stk  [DEPTH];
    int             m_sp;
    logic           m_zero, m_err;

    microc_stk #(.PC_W(PCW), .STK_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .pc(pc), .instr(instr), .Opcode(Opcode),
        .zero(zero), .s_inc(s_inc), .s_inm(s_inm), .we(we), .wez(wez),
        .ALUOp(ALUOp), .s_call(s_call), .s_ret(s_ret),
        .stk_empty(stk_empty), .stk_full(stk_full), .stk_err(stk_err));

    microc_stk #(.PC_W(4), .STK_DEPTH(2)) dut4 (
        .clk(clk), .reset(reset), .pc(pc4), .instr(instr), .Opcode(opcode4),
        .zero(zero4), .s_inc(s_inc), .s_inm(s_inm), .we(we), .wez(wez),
        .ALUOp(ALUOp), .s_call(s_call), .s_ret(s_ret),
        .stk_empty(empty4), .stk_full(full4), .stk_err(err4));

    always #5 clk = ~clk;

    task automatic drive(input logic [15:0] i, input logic inc, input logic inm,
                         input logic w, input logic wz, input logic [2:0] op,
                         input logic call, input logic ret);
        instr = i; s_inc = inc; s_inm = inm; we = w; wez = wz;
        ALUOp = op; s_call = call; s_ret = ret;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_pc = '0; m_sp = 0; m_zero = 1'b0; m_err = 1'b0;
        for (int k = 0; k < 16; k++) m_regs[k] = 8'd0;
        for (int k = 0; k < DEPTH; k++) m_stk[k] = '0;
    endtask

    task automatic do_reset();
        drive(16'h0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        model_reset();
    endtask

    // Applies the architectural rules to the model for the inputs now driven.
    task automatic model_step();
        int a, b, r, inc;
        if (s_inm) begin
            a = int'(instr[11:4]); b = int'(m_regs[instr[3:0]]);
        end else begin
            a = int'(m_regs[instr[11:8]]); b = int'(m_regs[instr[7:4]]);
        end
        case (ALUOp)
            3'd0: r = a;
            3'd1: r = 255 - a;
            3'd2: r = a + b;
            3'd3: r = a - b;
            3'd4: r = a & b;
            3'd5: r = a | b;
            3'd6: r = -a;
            default: r = -b;
        endcase
        r = ((r % 256) + 256) % 256;
        inc = (int'(m_pc) + 1) % (1 << PCW);
        if (s_ret) begin
            if (m_sp == 0) begin
                if (GUARD) begin m_pc = PCW'(inc); m_err = 1'b1; end
                else m_pc = m_stk[0];
            end else begin
                m_sp = m_sp - 1;
                m_pc = m_stk[m_sp];
            end
        end else if (!s_inc) begin
            if (s_call) begin
                if (m_sp == DEPTH) begin
                    if (GUARD) m_err = 1'b1;
                    else m_stk[m_sp % DEPTH] = PCW'(inc);
                end else begin
                    m_stk[m_sp] = PCW'(inc);
                    m_sp = m_sp + 1;
                end
            end
            m_pc = instr[PCW-1:0];
        end else begin
            m_pc = PCW'(inc);
        end
        if (we && instr[3:0] != 4'd0) m_regs[instr[3:0]] = 8'(r);
        if (wez) m_zero = (r == 0);
    endtask

    task automatic test_reset();
        do_reset();
        drive(16'h0051, 1'b1, 1'b1, 1'b1, 1'b1, 3'd0, 1'b0, 1'b0); step();
        drive(16'h0020, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0); step();
        drive(16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0); step();
        n_checks++;
        if (pc !== 10'h021 || zero !== 1'b1 || stk_empty !== 1'b0) begin
            n_fail++;
            $display("FAIL pre_reset: pc=%h zero=%b empty=%b expected pc=021 zero=1 empty=0", pc, zero, stk_empty);
        end
        #3 reset = 1'b0;
        #1;
        $display("reset asserted mid-cycle: pc=%h zero=%b empty=%b full=%b err=%b", pc, zero, stk_empty, stk_full, stk_err);
        n_checks++;
        if (pc !== 10'h000) begin n_fail++; $display("FAIL reset_pc: got %h expected 000", pc); end
        n_checks++;
        if (zero !== 1'b0) begin n_fail++; $display("FAIL reset_zero: got %b expected 0", zero); end
        n_checks++;
        if (stk_empty !== 1'b1 || stk_full !== 1'b0) begin
            n_fail++; $display("FAIL reset_stack: empty=%b full=%b expected 1 0", stk_empty, stk_full);
        end
        n_checks++;
        if (stk_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", stk_err); end
        for (int k = 1; k < 16; k++) begin
            n_checks++;
            if (dut.r_rf[k] !== 8'h00) begin
                n_fail++; $display("FAIL reset_reg r%0d: got %h expected 00", k, dut.r_rf[k]);
            end
        end
        @(negedge clk);
        reset = 1'b1;
        model_reset();
    endtask

    task automatic test_alu();
        do_reset();
        drive(16'h0051, 1'b1, 1'b1, 1'b1, 1'b1, 3'd0, 1'b0, 1'b0); step();
        $display("r1 <= imm 05: r1=%h zero=%b", dut.r_rf[1], zero);
        n_checks++;
        if (dut.r_rf[1] !== 8'h05 || zero !== 1'b0) begin
            n_fail++; $display("FAIL load_imm: r1=%h zero=%b expected 05 0", dut.r_rf[1], zero);
        end
        // r1 - r1 written to r0 (discarded)
        drive(16'h0110, 1'b1, 1'b0, 1'b1, 1'b1, 3'd3, 1'b0, 1'b0); step();
        $display("r1-r1 -> r0: zero=%b r1=%h r0=%h", zero, dut.r_rf[1], dut.r_rf[0]);
        n_checks++;
        if (zero !== 1'b1 || dut.r_rf[1] !== 8'h05 || dut.r_rf[0] !== 8'h00) begin
            n_fail++; $display("FAIL sub_zero: zero=%b r1=%h r0=%h expected 1 05 00", zero, dut.r_rf[1], dut.r_rf[0]);
        end
        drive(16'h0FF2, 1'b1, 1'b1, 1'b1, 1'b1, 3'd0, 1'b0, 1'b0); step();
        drive(16'h0013, 1'b1, 1'b1, 1'b1, 1'b1, 3'd0, 1'b0, 1'b0); step();
        drive(16'h0234, 1'b1, 1'b0, 1'b1, 1'b1, 3'd2, 1'b0, 1'b0); step();
        $display("r4 <= r2+r3 (FF+01): r4=%h zero=%b", dut.r_rf[4], zero);
        n_checks++;
        if (dut.r_rf[4] !== 8'h00 || zero !== 1'b1) begin
            n_fail++; $display("FAIL add_wrap: r4=%h zero=%b expected 00 1", dut.r_rf[4], zero);
        end
        // wez=0 must hold the flag
        drive(16'h0075, 1'b1, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0); step();
        n_checks++;
        if (zero !== 1'b1 || dut.r_rf[5] !== 8'h07) begin
            n_fail++; $display("FAIL zero_hold: zero=%b r5=%h expected 1 07", zero, dut.r_rf[5]);
        end
        drive(16'hA9C5, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
        #1;
        n_checks++;
        if (Opcode !== 6'h2A) begin n_fail++; $display("FAIL opcode: got %h expected 2a", Opcode); end
        step();
    endtask

    task automatic test_call_ret();
        do_reset();
        for (int k = 0; k < 3; k++) begin
            drive(16'h0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0); step();
        end
        drive(16'h0020, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0); step();
        $display("call 020 from 003: pc=%h empty=%b", pc, stk_empty);
        n_checks++;
        if (pc !== 10'h020 || stk_empty !== 1'b0) begin
            n_fail++; $display("FAIL call: pc=%h empty=%b expected 020 0", pc, stk_empty);
        end
        drive(16'h0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1); step();
        $display("ret: pc=%h empty=%b", pc, stk_empty);
        n_checks++;
        if (pc !== 10'h004 || stk_empty !== 1'b1) begin
            n_fail++; $display("FAIL ret: pc=%h empty=%b expected 004 1", pc, stk_empty);
        end
    endtask

    task automatic test_stack_full();
        logic [PCW-1:0] exp_ret [4];
        do_reset();
        for (int k = 1; k <= 5; k++) begin
            drive(16'(k * 16), 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0); step();
            $display("nested call %0d: pc=%h full=%b err=%b", k, pc, stk_full, stk_err);
        end
        n_checks++;
        if (pc !== 10'h050 || stk_full !== 1'b1 || stk_err !== GUARD) begin
            n_fail++; $display("FAIL overflow_call: pc=%h full=%b err=%b expected 050 1 %b", pc, stk_full, stk_err, GUARD);
        end
        if (GUARD) exp_ret = '{10'h031, 10'h021, 10'h011, 10'h001};
        else       exp_ret = '{10'h031, 10'h021, 10'h011, 10'h041};
        for (int k = 0; k < 4; k++) begin
            drive(16'h0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1); step();
            $display("return %0d: pc=%h", k, pc);
            n_checks++;
            if (pc !== exp_ret[k]) begin
                n_fail++; $display("FAIL lifo_ret%0d: got %h expected %h", k, pc, exp_ret[k]);
            end
        end
        n_checks++;
        if (stk_empty !== 1'b1) begin n_fail++; $display("FAIL drained: empty=%b expected 1", stk_empty); end
    endtask

    task automatic test_stack_empty();
        do_reset();
        drive(16'h0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0); step();
        drive(16'h0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0); step();
        drive(16'h0030, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0); step();
        drive(16'h0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1); step();
        drive(16'h0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1); step();
        $display("ret on empty stack: pc=%h empty=%b err=%b", pc, stk_empty, stk_err);
        n_checks++;
        if (pc !== (GUARD ? 10'h004 : 10'h003) || stk_empty !== 1'b1 || stk_err !== GUARD) begin
            n_fail++; $display("FAIL empty_ret: pc=%h empty=%b err=%b expected %h 1 %b",
                               pc, stk_empty, stk_err, (GUARD ? 10'h004 : 10'h003), GUARD);
        end
    endtask

    task automatic test_call_and_ret();
        do_reset();
        drive(16'h0010, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0); step();
        drive(16'h0055, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b1); step();
        $display("call+ret together: pc=%h empty=%b", pc, stk_empty);
        n_checks++;
        if (pc !== 10'h001 || stk_empty !== 1'b1) begin
            n_fail++; $display("FAIL call_ret_both: pc=%h empty=%b expected 001 1", pc, stk_empty);
        end
        drive(16'h0022, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0); step();
        $display("call with s_inc=1: pc=%h empty=%b", pc, stk_empty);
        n_checks++;
        if (pc !== 10'h002 || stk_empty !== 1'b1) begin
            n_fail++; $display("FAIL call_inc_ignored: pc=%h empty=%b expected 002 1", pc, stk_empty);
        end
    endtask

    task automatic test_pc_wrap();
        do_reset();
        for (int k = 1; k <= 17; k++) begin
            drive(16'h0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0); step();
            n_checks++;
            if (pc4 !== 4'(k % 16)) begin
                n_fail++; $display("FAIL pc4_wrap step %0d: got %h expected %h", k, pc4, 4'(k % 16));
            end
        end
        $display("PC_W=4 after 17 increments: pc=%h", pc4);
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 400; n++) begin
            logic inc;
            inc = ($urandom_range(0, 2) != 0);
            drive(16'($urandom), inc, 1'($urandom), 1'($urandom), 1'($urandom),
                  3'($urandom), ($urandom_range(0, 1) == 0), ($urandom_range(0, 4) == 0));
            model_step();
            step();
            n_checks++;
            if (pc !== m_pc || zero !== m_zero || stk_empty !== (m_sp == 0) ||
                stk_full !== (m_sp == DEPTH) || stk_err !== m_err) begin
                n_fail++;
                $display("FAIL random cycle %0d: pc=%h zero=%b e=%b f=%b err=%b expected pc=%h zero=%b e=%b f=%b err=%b",
                         n, pc, zero, stk_empty, stk_full, stk_err, m_pc, m_zero, (m_sp == 0), (m_sp == DEPTH), m_err);
            end
        end
        for (int k = 1; k < 16; k++) begin
            n_checks++;
            if (dut.r_rf[k] !== m_regs[k]) begin
                n_fail++; $display("FAIL random_reg r%0d: got %h expected %h", k, dut.r_rf[k], m_regs[k]);
            end
        end
        $display("random run: 400 instructions, final pc=%h sp_model=%0d", pc, m_sp);
    endtask

    initial begin
        model_reset();
        test_reset();
        test_alu();
        test_call_ret();
        test_stack_full();
        test_stack_empty();
        test_call_and_ret();
        test_pc_wrap();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
